// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back path into the 32x64 register file.
package wb_pkg;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wn;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load-result FIFO; every slot and its valid bit are visible so the issue stage
// can check pending destinations.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push,
  input  logic [REG_ADDR_W-1:0]            i_push_wn,
  input  logic [DATA_W-1:0]                i_push_wd,
  input  logic                             i_pop,
  output logic [REG_ADDR_W-1:0]            o_head_wn,
  output logic [DATA_W-1:0]                o_head_wd,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_ent_wn,
  output logic [DEPTH-1:0]                 o_ent_vld
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0][REG_ADDR_W-1:0] r_wn;
  logic [DEPTH-1:0][DATA_W-1:0]     r_wd;
  logic [DEPTH-1:0]                 r_vld;
  logic [PW-1:0]                    r_wr_ptr;
  logic [PW-1:0]                    r_rd_ptr;
  logic [PW:0]                      r_count;
  logic                             w_push;
  logic                             w_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_head_wn = r_wn[r_rd_ptr];
  assign o_head_wd = r_wd[r_rd_ptr];
  assign o_ent_wn  = r_wn;
  assign o_ent_vld = r_vld;

  // Push and pop never target the same slot: pop requires non-empty, push non-full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wn     <= '0;
      r_wd     <= '0;
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wn[r_wr_ptr]  <= i_push_wn;
        r_wd[r_wr_ptr]  <= i_push_wd;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// Merges fixed-latency ALU results and buffered load results into one registered
// register-file write per cycle. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_write_arbiter #(
  parameter int unsigned XLEN         = wb_pkg::XLEN,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [wb_pkg::REG_ADDR_W-1:0] alu_wn,
  input  logic [XLEN-1:0]             alu_wd,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [wb_pkg::REG_ADDR_W-1:0] ld_wn,
  input  logic [XLEN-1:0]             ld_wd,
  input  logic [wb_pkg::REG_ADDR_W-1:0] chk_rn1,
  input  logic [wb_pkg::REG_ADDR_W-1:0] chk_rn2,
  output logic                        chk_hit1,
  output logic                        chk_hit2,
  output logic                        alu_stall,
  output logic                        wb_regwrite,
  output logic [wb_pkg::REG_ADDR_W-1:0] wb_wn,
  output logic [XLEN-1:0]             wb_wd
);
  import wb_pkg::*;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("wb_write_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic                             w_full;
  logic                             w_empty;
  logic                             w_push;
  logic                             w_pop;
  logic                             w_alu_ok;
  logic                             w_alu_win;
  logic [REG_ADDR_W-1:0]            w_head_wn;
  logic [XLEN-1:0]                  w_head_wd;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_ent_wn;
  logic [DEPTH-1:0]                 w_ent_vld;
  logic                             r_regwrite;
  logic [REG_ADDR_W-1:0]            r_wn;
  logic [XLEN-1:0]                  r_wd;

  assign ld_ready  = !w_full;
  assign w_push    = ld_valid && !w_full && (ld_wn != X0_ADDR);
  assign w_alu_win = w_alu_ok && alu_valid && (alu_wn != X0_ADDR);
  assign w_pop     = !w_empty && !w_alu_win;

  wb_load_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_push_wn (ld_wn),
    .i_push_wd (ld_wd),
    .i_pop     (w_pop),
    .o_head_wn (w_head_wn),
    .o_head_wd (w_head_wd),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_ent_wn  (w_ent_wn),
    .o_ent_vld (w_ent_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite <= 1'b0;
      r_wn       <= '0;
      r_wd       <= '0;
    end else if (w_alu_win) begin
      r_regwrite <= 1'b1;
      r_wn       <= alu_wn;
      r_wd       <= alu_wd;
    end else if (w_pop) begin
      r_regwrite <= 1'b1;
      r_wn       <= w_head_wn;
      r_wd       <= w_head_wd;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign wb_regwrite = r_regwrite;
  assign wb_wn       = r_wn;
  assign wb_wd       = r_wd;

  // The head being popped this cycle is still valid, so it still reports a hit.
  always_comb begin
    chk_hit1 = 1'b0;
    chk_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_wn[i] == chk_rn1)) chk_hit1 = 1'b1;
      if (w_ent_vld[i] && (w_ent_wn[i] == chk_rn2)) chk_hit2 = 1'b1;
    end
    if (chk_rn1 == X0_ADDR) chk_hit1 = 1'b0;
    if (chk_rn2 == X0_ADDR) chk_hit2 = 1'b0;
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          r_stall;

  assign w_alu_ok  = !r_stall;
  assign alu_stall = r_stall;

  // Stall is raised on the edge where the counter reaches the limit, so the
  // following cycle forces a pop, which in turn clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= 1'b0;
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (w_alu_win) begin
        r_starve <= r_starve + 1'b1;
        r_stall  <= (r_starve == SW'(STARVE_LIMIT - 1));
      end
    end
  end

  a_no_alu_during_stall : assert property (@(posedge clk) disable iff (!rst_n) !(r_stall && alu_valid))
    else $error("wb_write_arbiter: alu_valid presented during alu_stall is dropped");
`else
  assign w_alu_ok  = 1'b1;
  assign alu_stall = 1'b0;
`endif
endmodule
